// File: rtl/snd_mbox_pkg.sv
// Shared types and constants for the 68k-side sound mailbox.
package snd_mbox_pkg;

  typedef enum logic [1:0] {
    NMI_IDLE,
    NMI_PULSE,
    NMI_GAP
  } nmi_state_t;

  // Bit positions inside m_status
  localparam int ST_CMD_FULL   = 0;
  localparam int ST_RESP_AVAIL = 1;
  localparam int ST_CMD_OVR    = 2;
  localparam int ST_RESP_OVR   = 3;

  // Bit positions inside a control write
  localparam int CTL_RST_BIT = 0;
  localparam int CTL_CLR_BIT = 1;

endpackage

// File: rtl/snd_resp_fifo.sv
// First-word-fall-through response queue; head reads as zero while empty.
module snd_resp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     drop
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full = (count_q == CNT_W'(DEPTH));
  assign count = count_q;
  assign head = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

  // A pop in the same cycle frees the slot a push into a full queue needs.
  assign do_pop  = pop && (count_q != '0) && !flush;
  assign do_push = push && (!full || do_pop) && !flush;
  assign drop    = push && full && !do_pop && !flush;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; empty slots are never visible because head is masked by count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/snd_mailbox_main.sv
// 68k end of the sound-board mailbox: command latch + NMI pulser, response
// queue + IRQ, and the sound-CPU reset with a minimum low time.
module snd_mailbox_main #(
  parameter int NMI_W      = 8,
  parameter int NMI_GAP    = 4,
  parameter int RST_MIN    = 16,
  parameter int RESP_DEPTH = 4
) (
  input  logic       phi0,
  input  logic       rst_b,
  input  logic       m_wr_cmd,
  input  logic       m_wr_ctl,
  input  logic [7:0] m_din,
  input  logic       m_rd_resp,
  output logic [7:0] m_dout,
  output logic [3:0] m_status,
  output logic       m_irq_b,
  input  logic       snd_rd_cmd,
  output logic [7:0] snd_cmd,
  input  logic       SNDBW_b,
  input  logic [7:0] snd_din,
  output logic       SNDNMI_b,
  output logic       SNDRST_b
);
  import snd_mbox_pkg::*;

  localparam int NMI_MAX = (NMI_W > NMI_GAP) ? NMI_W : NMI_GAP;
  localparam int NMI_CW  = $clog2(NMI_MAX + 1);
  localparam int RST_CW  = $clog2(RST_MIN + 1);
  localparam int CNT_W   = $clog2(RESP_DEPTH) + 1;

  logic [7:0]        cmd_reg_q, cmd_reg_d;
  logic              cmd_full_q, cmd_full_d;
  logic              cmd_ovr_q, cmd_ovr_d;
  logic              resp_ovr_q, resp_ovr_d;
  logic              nmi_pend_q, nmi_pend_d;
  nmi_state_t        nmi_state_q, nmi_state_d;
  logic [NMI_CW-1:0] nmi_cnt_q, nmi_cnt_d;
  logic              snd_nmi_b_q, snd_nmi_b_d;
  logic              snd_rst_b_q, snd_rst_b_d;
  logic [RST_CW-1:0] rst_cnt_q, rst_cnt_d;
  logic              rst_req_q, rst_req_d;
  logic              irq_b_q, irq_b_d;

  logic              rst_set, flag_clr, hold;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full, fifo_drop;

  assign rst_set  = m_wr_ctl && m_din[CTL_RST_BIT];
  assign flag_clr = m_wr_ctl && m_din[CTL_CLR_BIT];
  // The sound side is held from the very cycle the reset request is written.
  assign hold     = !snd_rst_b_q || rst_set;

  snd_resp_fifo #(.DEPTH(RESP_DEPTH), .WIDTH(8)) u_resp_fifo (
    .clk       (phi0),
    .rst_b     (rst_b),
    .flush     (hold),
    .push      (!SNDBW_b),
    .push_data (snd_din),
    .pop       (m_rd_resp),
    .head      (m_dout),
    .count     (fifo_count),
    .full      (fifo_full),
    .drop      (fifo_drop)
  );

  always_comb begin
    rst_req_d = m_wr_ctl ? m_din[CTL_RST_BIT] : rst_req_q;
    rst_cnt_d = rst_cnt_q;
    if (rst_set)                             rst_cnt_d = RST_CW'(RST_MIN);
    else if (!snd_rst_b_q && rst_cnt_q != '0) rst_cnt_d = rst_cnt_q - RST_CW'(1);
    snd_rst_b_d = !rst_req_d && (rst_cnt_d == '0);

    cmd_reg_d  = m_wr_cmd ? m_din : cmd_reg_q;
    cmd_full_d = cmd_full_q;
    if (hold)            cmd_full_d = 1'b0;
    else if (m_wr_cmd)   cmd_full_d = 1'b1;
    else if (snd_rd_cmd) cmd_full_d = 1'b0;

    cmd_ovr_d  = (m_wr_cmd && cmd_full_q && !snd_rd_cmd && !hold) || (cmd_ovr_q && !flag_clr);
    resp_ovr_d = fifo_drop || (resp_ovr_q && !flag_clr);
    irq_b_d    = (fifo_count == '0);
  end

  // The NMI_GAP parameter shadows the enum literal here, hence the qualified name.
  always_comb begin
    nmi_state_d = nmi_state_q;
    nmi_cnt_d   = nmi_cnt_q;
    snd_nmi_b_d = snd_nmi_b_q;
    nmi_pend_d  = nmi_pend_q || m_wr_cmd;
    if (hold) begin
      nmi_state_d = NMI_IDLE;
      nmi_cnt_d   = '0;
      snd_nmi_b_d = 1'b1;
      nmi_pend_d  = 1'b0;
    end else begin
      case (nmi_state_q)
        NMI_IDLE: if (nmi_pend_q) begin
          nmi_state_d = NMI_PULSE;
          nmi_cnt_d   = NMI_CW'(NMI_W - 1);
          snd_nmi_b_d = 1'b0;
          nmi_pend_d  = m_wr_cmd;
        end
        NMI_PULSE: if (nmi_cnt_q == '0) begin
          nmi_state_d = snd_mbox_pkg::NMI_GAP;
          nmi_cnt_d   = NMI_CW'(NMI_GAP - 1);
          snd_nmi_b_d = 1'b1;
        end else begin
          nmi_cnt_d = nmi_cnt_q - NMI_CW'(1);
        end
        snd_mbox_pkg::NMI_GAP: if (nmi_cnt_q == '0) nmi_state_d = NMI_IDLE;
                               else nmi_cnt_d = nmi_cnt_q - NMI_CW'(1);
        default: begin
          nmi_state_d = NMI_IDLE;
          snd_nmi_b_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge phi0) begin
    if (!rst_b) begin
      cmd_reg_q   <= '0;
      cmd_full_q  <= 1'b0;
      cmd_ovr_q   <= 1'b0;
      resp_ovr_q  <= 1'b0;
      nmi_pend_q  <= 1'b0;
      nmi_state_q <= NMI_IDLE;
      nmi_cnt_q   <= '0;
      snd_nmi_b_q <= 1'b1;
      snd_rst_b_q <= 1'b0;
      rst_cnt_q   <= RST_CW'(RST_MIN);
      rst_req_q   <= 1'b1;
      irq_b_q     <= 1'b1;
    end else begin
      cmd_reg_q   <= cmd_reg_d;
      cmd_full_q  <= cmd_full_d;
      cmd_ovr_q   <= cmd_ovr_d;
      resp_ovr_q  <= resp_ovr_d;
      nmi_pend_q  <= nmi_pend_d;
      nmi_state_q <= nmi_state_d;
      nmi_cnt_q   <= nmi_cnt_d;
      snd_nmi_b_q <= snd_nmi_b_d;
      snd_rst_b_q <= snd_rst_b_d;
      rst_cnt_q   <= rst_cnt_d;
      rst_req_q   <= rst_req_d;
      irq_b_q     <= irq_b_d;
    end
  end

  always_comb begin
    m_status                = '0;
    m_status[ST_CMD_FULL]   = cmd_full_q;
    m_status[ST_RESP_AVAIL] = (fifo_count != '0);
    m_status[ST_CMD_OVR]    = cmd_ovr_q;
    m_status[ST_RESP_OVR]   = resp_ovr_q;
  end

  assign m_irq_b  = irq_b_q;
  assign snd_cmd  = cmd_reg_q;
  assign SNDNMI_b = snd_nmi_b_q;
  assign SNDRST_b = snd_rst_b_q;

endmodule

// File: tb/tb_snd_mailbox_main.sv
// Directed bench for snd_mailbox_main; outputs are sampled 1 ns after each rising edge.
module tb_snd_mailbox_main;

  logic       phi0 = 1'b0;
  logic       rst_b;
  logic       m_wr_cmd, m_wr_ctl, m_rd_resp, snd_rd_cmd, SNDBW_b;
  logic [7:0] m_din, snd_din;
  logic [7:0] m_dout, snd_cmd;
  logic [3:0] m_status;
  logic       m_irq_b, SNDNMI_b, SNDRST_b;

  int n_asserts = 0;
  int n_fails   = 0;

  // NMI pulse monitor, updated on every sample
  logic prev_nmi  = 1'b1;
  int   nmi_falls = 0;
  int   high_run  = 0;
  int   min_gap   = 1000;

  always #5 phi0 = ~phi0;

  snd_mailbox_main dut (
    .phi0       (phi0),
    .rst_b      (rst_b),
    .m_wr_cmd   (m_wr_cmd),
    .m_wr_ctl   (m_wr_ctl),
    .m_din      (m_din),
    .m_rd_resp  (m_rd_resp),
    .m_dout     (m_dout),
    .m_status   (m_status),
    .m_irq_b    (m_irq_b),
    .snd_rd_cmd (snd_rd_cmd),
    .snd_cmd    (snd_cmd),
    .SNDBW_b    (SNDBW_b),
    .snd_din    (snd_din),
    .SNDNMI_b   (SNDNMI_b),
    .SNDRST_b   (SNDRST_b)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge phi0);
    #1;
    if (prev_nmi && !SNDNMI_b) begin
      nmi_falls++;
      if (nmi_falls > 1 && high_run < min_gap) min_gap = high_run;
    end
    if (SNDNMI_b) high_run++;
    else          high_run = 0;
    prev_nmi = SNDNMI_b;
  endtask

  task automatic idle_inputs();
    m_wr_cmd   = 1'b0;
    m_wr_ctl   = 1'b0;
    m_rd_resp  = 1'b0;
    snd_rd_cmd = 1'b0;
    SNDBW_b    = 1'b1;
    m_din      = 8'h00;
    snd_din    = 8'h00;
  endtask

  task automatic push_resp(input logic [7:0] v);
    SNDBW_b = 1'b0;
    snd_din = v;
    step();
    SNDBW_b = 1'b1;
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] v);
    check(tag, m_dout, v);
    m_rd_resp = 1'b1;
    step();
    m_rd_resp = 1'b0;
  endtask

  task automatic ctl_write(input logic [7:0] v);
    m_wr_ctl = 1'b1;
    m_din    = v;
    step();
    m_wr_ctl = 1'b0;
    m_din    = 8'h00;
  endtask

  task automatic cmd_write(input logic [7:0] v);
    m_wr_cmd = 1'b1;
    m_din    = v;
    step();
    m_wr_cmd = 1'b0;
    m_din    = 8'h00;
  endtask

  initial begin
    idle_inputs();
    rst_b = 1'b0;
    repeat (3) step();

    // Reset state
    check("rst_sndrst", 8'(SNDRST_b), 8'h00);
    check("rst_sndnmi", 8'(SNDNMI_b), 8'h01);
    check("rst_irq", 8'(m_irq_b), 8'h01);
    check("rst_dout", m_dout, 8'h00);
    check("rst_status", 8'(m_status), 8'h00);
    check("rst_sndcmd", snd_cmd, 8'h00);

    // 1: release request in the first cycle out of reset; low 16 cycles from the last reset edge
    rst_b = 1'b1;
    ctl_write(8'h00);
    repeat (14) step();
    check("rel_still_low", 8'(SNDRST_b), 8'h00);
    step();
    check("rel_high", 8'(SNDRST_b), 8'h01);
    check("rel_nmi_idle", 8'(SNDNMI_b), 8'h01);

    // 2: one command, one 8-cycle NMI starting one cycle after the write edge
    cmd_write(8'h5A);
    check("cmd_full_set", 8'(m_status), 8'h01);
    check("cmd_latched", snd_cmd, 8'h5A);
    check("nmi_not_yet", 8'(SNDNMI_b), 8'h01);
    step();
    check("nmi_start", 8'(SNDNMI_b), 8'h00);
    repeat (7) step();
    check("nmi_last_low", 8'(SNDNMI_b), 8'h00);
    step();
    check("nmi_end", 8'(SNDNMI_b), 8'h01);
    snd_rd_cmd = 1'b1;
    step();
    snd_rd_cmd = 1'b0;
    check("rd_cmd_byte", snd_cmd, 8'h5A);
    check("rd_cmd_clr", 8'(m_status), 8'h00);
    repeat (6) step();

    // 3: three writes two cycles apart -> overrun, exactly two pulses
    nmi_falls = 0;
    min_gap   = 1000;
    cmd_write(8'h01);
    step();
    cmd_write(8'h02);
    step();
    cmd_write(8'h03);
    check("ovr_status", 8'(m_status), 8'h05);
    check("ovr_last_byte", snd_cmd, 8'h03);
    repeat (40) step();
    check("nmi_pulse_count", 8'(nmi_falls), 8'd2);
    check("nmi_gap_min4", 8'(min_gap >= 4), 8'h01);
    snd_rd_cmd = 1'b1;
    step();
    snd_rd_cmd = 1'b0;
    check("ovr_sticky", 8'(m_status), 8'h04);
    ctl_write(8'h02);
    check("ovr_cleared", 8'(m_status), 8'h00);

    // 4: five pushes into a 4-deep queue -> overrun, four pops in order
    push_resp(8'h11);
    push_resp(8'h22);
    push_resp(8'h33);
    push_resp(8'h44);
    push_resp(8'h55);
    check("resp_ovr_status", 8'(m_status), 8'h0A);
    check("resp_irq_low", 8'(m_irq_b), 8'h00);
    pop_expect("pop_11", 8'h11);
    pop_expect("pop_22", 8'h22);
    pop_expect("pop_33", 8'h33);
    pop_expect("pop_44", 8'h44);
    check("empty_status", 8'(m_status), 8'h08);
    check("empty_dout", m_dout, 8'h00);
    check("irq_lags_count", 8'(m_irq_b), 8'h00);
    step();
    check("irq_release", 8'(m_irq_b), 8'h01);
    m_rd_resp = 1'b1;
    step();
    m_rd_resp = 1'b0;
    check("pop_empty_ignored", 8'(m_status), 8'h08);
    ctl_write(8'h02);
    check("resp_ovr_cleared", 8'(m_status), 8'h00);

    // 5: push and pop together while full -> no overrun
    push_resp(8'h71);
    push_resp(8'h72);
    push_resp(8'h73);
    push_resp(8'h74);
    check("full_status", 8'(m_status), 8'h02);
    check("full_head", m_dout, 8'h71);
    SNDBW_b   = 1'b0;
    snd_din   = 8'h66;
    m_rd_resp = 1'b1;
    step();
    SNDBW_b   = 1'b1;
    m_rd_resp = 1'b0;
    check("simul_no_ovr", 8'(m_status), 8'h02);
    pop_expect("pop_72", 8'h72);
    pop_expect("pop_73", 8'h73);
    pop_expect("pop_74", 8'h74);
    pop_expect("pop_66", 8'h66);
    check("simul_drained", 8'(m_status), 8'h00);
    step();

    // 6: sound reset mid-pulse with two queued responses
    push_resp(8'hA1);
    push_resp(8'hA2);
    cmd_write(8'h3C);
    step();
    step();
    check("pre_rst_nmi_low", 8'(SNDNMI_b), 8'h00);
    ctl_write(8'h01);
    check("hold_nmi_high", 8'(SNDNMI_b), 8'h01);
    check("hold_sndrst_low", 8'(SNDRST_b), 8'h00);
    check("hold_flushed", 8'(m_status), 8'h00);
    check("hold_dout", m_dout, 8'h00);
    ctl_write(8'h00);
    check("hold_irq_high", 8'(m_irq_b), 8'h01);
    m_wr_cmd = 1'b1;
    m_din    = 8'h77;
    SNDBW_b  = 1'b0;
    snd_din  = 8'hEE;
    step();
    idle_inputs();
    check("hold_cmd_loaded", snd_cmd, 8'h77);
    check("hold_no_flags", 8'(m_status), 8'h00);
    repeat (13) step();
    check("min_low_16", 8'(SNDRST_b), 8'h00);
    step();
    check("rst_released", 8'(SNDRST_b), 8'h01);
    repeat (3) step();
    check("no_stale_nmi", 8'(SNDNMI_b), 8'h01);
    check("no_stale_full", 8'(m_status), 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
